// File: rtl/lpif_online_seq_ctrl.sv
// LPIF online sequencing controller.
// Brings the link datapath online in two steps (tx, then rx), qualifies the
// PHY, waits for remote alignment, and retries a bounded number of times
// before parking in FAIL. A single shared timer serves every timed state.
module lpif_online_seq_ctrl #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned RETRY_GAP  = 8,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk_wr,
  input  logic        rst_wr,
  input  logic        enable,
  input  logic [1:0]  phy_ready,
  input  logic        rx_align_done,
  input  logic [15:0] timeout_value,
  output logic        tx_online,
  output logic        rx_online,
  output logic        link_up,
  output logic        link_fail,
  output logic [1:0]  retry_cnt,
  output logic [2:0]  ctrl_state,
  output logic [31:0] debug_status
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PHY = 3'd1,
    S_TX_ON    = 3'd2,
    S_RX_ON    = 3'd3,
    S_LINK_UP  = 3'd4,
    S_RETRY    = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  // Last timer value spent in a timed state before leaving it.
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] RETRY_LAST  = 16'(RETRY_GAP - 1);

  state_t      r_state;
  logic [15:0] r_timer;
  logic [1:0]  r_retry_cnt;
  logic        r_tx_online;
  logic        r_rx_online;
  logic        r_link_up;
  logic        r_link_fail;

  state_t      w_state_next;
  logic [15:0] w_timer_next;
  logic [1:0]  w_retry_next;
  logic        w_phy_ok;

  assign w_phy_ok = (phy_ready == 2'b11);

  // Next-state, shared timer and retry counter computation.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_retry_next = r_retry_cnt;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_next = S_WAIT_PHY;
      end
      S_WAIT_PHY: begin
        // Timer counts consecutive good samples; any bad sample restarts it.
        if (w_phy_ok) begin
          if (r_timer != 16'd0) w_state_next = S_TX_ON;
          else                  w_timer_next = 16'd1;
        end else begin
          w_timer_next = 16'd0;
        end
      end
      S_TX_ON: begin
        // Alignment wins over a coincident timeout.
        if (rx_align_done)
          w_state_next = S_RX_ON;
        else if ((timeout_value != 16'd0) && (r_timer == timeout_value))
          w_state_next = S_RETRY;
        else if (r_timer != 16'hFFFF)
          w_timer_next = r_timer + 16'd1;
      end
      S_RX_ON: begin
        if (!rx_align_done || !w_phy_ok) w_state_next = S_RETRY;
        else if (r_timer >= SETTLE_LAST) w_state_next = S_LINK_UP;
        else                             w_timer_next = r_timer + 16'd1;
      end
      S_LINK_UP: begin
        if (!rx_align_done || !w_phy_ok) w_state_next = S_RETRY;
      end
      S_RETRY: begin
        if (r_timer >= RETRY_LAST) begin
          if (32'(r_retry_cnt) >= MAX_RETRY) w_state_next = S_FAIL;
          else                               w_state_next = S_WAIT_PHY;
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      S_FAIL: begin
        w_state_next = S_FAIL;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Dropping enable overrides every other transition.
    if (!enable) w_state_next = S_IDLE;

    if (w_state_next != r_state) begin
      w_timer_next = 16'd0;
      if ((w_state_next == S_RETRY) && (r_retry_cnt != 2'd3))
        w_retry_next = r_retry_cnt + 2'd1;
    end

    if (w_state_next == S_IDLE) begin
      w_timer_next = 16'd0;
      w_retry_next = 2'd0;
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they are registered alongside it.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_state     <= S_IDLE;
      r_timer     <= 16'd0;
      r_retry_cnt <= 2'd0;
      r_tx_online <= 1'b0;
      r_rx_online <= 1'b0;
      r_link_up   <= 1'b0;
      r_link_fail <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_retry_cnt <= w_retry_next;
      r_tx_online <= (w_state_next == S_TX_ON) || (w_state_next == S_RX_ON) ||
                     (w_state_next == S_LINK_UP);
      r_rx_online <= (w_state_next == S_RX_ON) || (w_state_next == S_LINK_UP);
      r_link_up   <= (w_state_next == S_LINK_UP);
      r_link_fail <= (w_state_next == S_FAIL);
    end
  end

  assign tx_online  = r_tx_online;
  assign rx_online  = r_rx_online;
  assign link_up    = r_link_up;
  assign link_fail  = r_link_fail;
  assign retry_cnt  = r_retry_cnt;
  assign ctrl_state = r_state;

  // Field layout: [20] fail, [19] up, [18] rx, [17] tx, [16:14] state,
  // [13:12] retry count, [11:0] timer; upper bits zero so the word is 32 bits.
  assign debug_status = {11'h0, r_link_fail, r_link_up, r_rx_online, r_tx_online,
                         r_state, r_retry_cnt, r_timer[11:0]};

endmodule

// File: tb/tb_lpif_online_seq_ctrl.sv
// Directed testbench for lpif_online_seq_ctrl.
module tb_lpif_online_seq_ctrl;

  logic        clk_wr = 1'b0;
  logic        rst_wr;
  logic        enable;
  logic [1:0]  phy_ready;
  logic        rx_align_done;
  logic [15:0] timeout_value;
  logic        tx_online, rx_online, link_up, link_fail;
  logic [1:0]  retry_cnt;
  logic [2:0]  ctrl_state;
  logic [31:0] debug_status;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed view {tx, rx, up, fail, state[2:0], retry[1:0]}.
  logic [8:0] obs;
  assign obs = {tx_online, rx_online, link_up, link_fail, ctrl_state, retry_cnt};

  lpif_online_seq_ctrl dut (
    .clk_wr        (clk_wr),
    .rst_wr        (rst_wr),
    .enable        (enable),
    .phy_ready     (phy_ready),
    .rx_align_done (rx_align_done),
    .timeout_value (timeout_value),
    .tx_online     (tx_online),
    .rx_online     (rx_online),
    .link_up       (link_up),
    .link_fail     (link_fail),
    .retry_cnt     (retry_cnt),
    .ctrl_state    (ctrl_state),
    .debug_status  (debug_status)
  );

  always #5 clk_wr = ~clk_wr;

  // Advance n clocks, landing 1 ns after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_wr);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_wr = 1'b1; enable = 1'b0; phy_ready = 2'b00;
    rx_align_done = 1'b0; timeout_value = 16'd0;
    step(2);
    n_checks++;
    if (obs !== 9'b0000_000_00) begin
      n_fail++; $display("FAIL reset_obs got %b want %b", obs, 9'b0000_000_00);
    end
    n_checks++;
    if (debug_status !== 32'h0) begin
      n_fail++; $display("FAIL reset_debug got %h want %h", debug_status, 32'h0);
    end
    rst_wr = 1'b0;
    step(1);
    n_checks++;
    if (obs !== 9'b0000_000_00) begin
      n_fail++; $display("FAIL idle_hold got %b want %b", obs, 9'b0000_000_00);
    end
    $display("test_reset done");
  endtask

  task automatic test_bringup();
    enable = 1'b1; phy_ready = 2'b11; rx_align_done = 1'b0; timeout_value = 16'd0;
    step(1);
    n_checks++;
    if (obs !== 9'b0000_001_00) begin
      n_fail++; $display("FAIL bringup_wait_phy got %b want %b", obs, 9'b0000_001_00);
    end
    step(2);
    n_checks++;
    if (obs !== 9'b1000_010_00) begin
      n_fail++; $display("FAIL bringup_tx_on got %b want %b", obs, 9'b1000_010_00);
    end
    step(10);
    rx_align_done = 1'b1;
    step(1);
    n_checks++;
    if (obs !== 9'b1100_011_00) begin
      n_fail++; $display("FAIL bringup_rx_on got %b want %b", obs, 9'b1100_011_00);
    end
    step(3);
    n_checks++;
    if (obs !== 9'b1100_011_00) begin
      n_fail++; $display("FAIL bringup_settle got %b want %b", obs, 9'b1100_011_00);
    end
    step(1);
    n_checks++;
    if (obs !== 9'b1110_100_00) begin
      n_fail++; $display("FAIL bringup_link_up got %b want %b", obs, 9'b1110_100_00);
    end
    n_checks++;
    if (debug_status !== 32'h000F_0000) begin
      n_fail++; $display("FAIL bringup_debug got %h want %h", debug_status, 32'h000F_0000);
    end
    $display("test_bringup done");
  endtask

  task automatic test_link_drop();
    phy_ready = 2'b01;
    step(1);
    phy_ready = 2'b11;
    n_checks++;
    if (obs !== 9'b0000_101_01) begin
      n_fail++; $display("FAIL drop_retry got %b want %b", obs, 9'b0000_101_01);
    end
    step(7);
    n_checks++;
    if (obs !== 9'b0000_101_01) begin
      n_fail++; $display("FAIL drop_gap got %b want %b", obs, 9'b0000_101_01);
    end
    step(1);
    n_checks++;
    if (obs !== 9'b0000_001_01) begin
      n_fail++; $display("FAIL drop_wait_phy got %b want %b", obs, 9'b0000_001_01);
    end
    step(3);
    n_checks++;
    if (obs !== 9'b1100_011_01) begin
      n_fail++; $display("FAIL drop_rx_on got %b want %b", obs, 9'b1100_011_01);
    end
    step(4);
    n_checks++;
    if (obs !== 9'b1110_100_01) begin
      n_fail++; $display("FAIL drop_relink got %b want %b", obs, 9'b1110_100_01);
    end
    $display("test_link_drop done");
  endtask

  task automatic test_timeout();
    enable = 1'b0;
    step(1);
    n_checks++;
    if (obs !== 9'b0000_000_00) begin
      n_fail++; $display("FAIL to_idle got %b want %b", obs, 9'b0000_000_00);
    end
    enable = 1'b1; rx_align_done = 1'b0; timeout_value = 16'd20; phy_ready = 2'b11;
    step(3);
    step(20);
    n_checks++;
    if ({obs, debug_status[11:0]} !== {9'b1000_010_00, 12'd20}) begin
      n_fail++; $display("FAIL to_last_tx got %b/%0d want %b/20", obs, debug_status[11:0], 9'b1000_010_00);
    end
    step(1);
    n_checks++;
    if (obs !== 9'b0000_101_01) begin
      n_fail++; $display("FAIL to_retry1 got %b want %b", obs, 9'b0000_101_01);
    end
    step(8);
    n_checks++;
    if (obs !== 9'b0000_001_01) begin
      n_fail++; $display("FAIL to_wait_phy got %b want %b", obs, 9'b0000_001_01);
    end
    step(2 + 21);
    n_checks++;
    if (obs !== 9'b0000_101_10) begin
      n_fail++; $display("FAIL to_retry2 got %b want %b", obs, 9'b0000_101_10);
    end
    step(8 + 2 + 21);
    n_checks++;
    if (obs !== 9'b0000_101_11) begin
      n_fail++; $display("FAIL to_retry3 got %b want %b", obs, 9'b0000_101_11);
    end
    step(8);
    n_checks++;
    if (obs !== 9'b0001_110_11) begin
      n_fail++; $display("FAIL to_fail got %b want %b", obs, 9'b0001_110_11);
    end
    step(10);
    n_checks++;
    if (obs !== 9'b0001_110_11) begin
      n_fail++; $display("FAIL to_fail_hold got %b want %b", obs, 9'b0001_110_11);
    end
    enable = 1'b0;
    step(1);
    n_checks++;
    if (obs !== 9'b0000_000_00) begin
      n_fail++; $display("FAIL to_fail_exit got %b want %b", obs, 9'b0000_000_00);
    end
    $display("test_timeout done");
  endtask

  task automatic test_simultaneous();
    enable = 1'b1; rx_align_done = 1'b0; timeout_value = 16'd20; phy_ready = 2'b11;
    step(3 + 20);
    rx_align_done = 1'b1;
    step(1);
    n_checks++;
    if (obs !== 9'b1100_011_00) begin
      n_fail++; $display("FAIL sim_align_wins got %b want %b", obs, 9'b1100_011_00);
    end
    step(3);
    enable = 1'b0;
    step(1);
    n_checks++;
    if (obs !== 9'b0000_000_00) begin
      n_fail++; $display("FAIL sim_enable_wins got %b want %b", obs, 9'b0000_000_00);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_phy_glitch();
    enable = 1'b1; rx_align_done = 1'b0; timeout_value = 16'd0; phy_ready = 2'b00;
    step(1);
    phy_ready = 2'b11; step(1);
    phy_ready = 2'b10; step(1);
    n_checks++;
    if (obs !== 9'b0000_001_00) begin
      n_fail++; $display("FAIL glitch_bad got %b want %b", obs, 9'b0000_001_00);
    end
    phy_ready = 2'b11; step(1);
    n_checks++;
    if (obs !== 9'b0000_001_00) begin
      n_fail++; $display("FAIL glitch_first_good got %b want %b", obs, 9'b0000_001_00);
    end
    step(1);
    n_checks++;
    if (obs !== 9'b1000_010_00) begin
      n_fail++; $display("FAIL glitch_tx_on got %b want %b", obs, 9'b1000_010_00);
    end
    $display("test_phy_glitch done");
  endtask

  task automatic test_no_timeout();
    step(300);
    n_checks++;
    if ({obs, debug_status[11:0]} !== {9'b1000_010_00, 12'd300}) begin
      n_fail++; $display("FAIL notimeout_hold got %b/%0d want %b/300", obs, debug_status[11:0], 9'b1000_010_00);
    end
    $display("test_no_timeout done");
  endtask

  task automatic test_async_reset();
    rx_align_done = 1'b1;
    step(5);
    n_checks++;
    if (obs !== 9'b1110_100_00) begin
      n_fail++; $display("FAIL areset_pre_link got %b want %b", obs, 9'b1110_100_00);
    end
    #2 rst_wr = 1'b1;
    #1;
    n_checks++;
    if ({obs, debug_status} !== {9'b0, 32'h0}) begin
      n_fail++; $display("FAIL areset_immediate got %b/%h want 0/0", obs, debug_status);
    end
    step(1);
    rst_wr = 1'b0;
    step(1);
    n_checks++;
    if (obs !== 9'b0000_001_00) begin
      n_fail++; $display("FAIL areset_resume got %b want %b", obs, 9'b0000_001_00);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_link_drop();
    test_timeout();
    test_simultaneous();
    test_phy_glitch();
    test_no_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
